// File: rtl/posit_extract_if.sv
// Handshake and decoded-value bundle for posit_extract_pipe.
// slave is the decoder's view; master is the producer/consumer view.
interface posit_extract_if #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - 3 - ES
);
  logic                    in_valid;
  logic [NBITS-1:0]        in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic signed [7:0]       out_scale;
  logic [ES-1:0]           out_exponent;
  logic [FBITS-1:0]        out_fraction;
  logic                    out_inf;
  logic                    out_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero
  );
endinterface

// File: rtl/posit_extract_pipe.sv
// Three-stage posit decoder (S1 sign/abs, S2 regime decode, S3 output) with
// lock-step backpressure. Define POSIT_EXTRACT_CNT_EN to add NaR/zero counters.
module posit_extract_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - 3 - ES
) (
  input  logic                 clk,
  input  logic                 reset,
  posit_extract_if.slave       io
`ifdef POSIT_EXTRACT_CNT_EN
  ,
  input  logic                 clr_cnt,
  output logic [15:0]          cnt_nar,
  output logic [15:0]          cnt_zero
`endif
);

  // k is stored narrow so that {k, exponent} is exactly the 8-bit scale.
  localparam int KW = 8 - ES;

  logic advance;
  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;

  // ---------------- S1: classify, sign, magnitude ----------------
  logic             s1_valid, s1_sign, s1_zero, s1_inf;
  logic [NBITS-2:0] s1_abs;

  // NOTE: state is written with <= so every stage samples the previous
  // stage's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_abs   <= '0;
    end else if (advance) begin
      s1_valid <= io.in_valid;
      s1_sign  <= io.in_data[NBITS-1];
      s1_zero  <= (io.in_data == '0);
      s1_inf   <= (io.in_data == {1'b1, {(NBITS-1){1'b0}}});
      // Low bits of a two's-complement negation depend only on low bits.
      s1_abs   <= io.in_data[NBITS-1] ? (~io.in_data[NBITS-2:0]) + (NBITS-1)'(1)
                                      : io.in_data[NBITS-2:0];
    end
  end

  // ---------------- S2: regime run length, exponent, fraction ----------------
  logic [KW-1:0]        run;
  logic                 done;
  logic signed [KW-1:0] dec_k;
  logic [NBITS-4:0]     tail_sh;
  logic [ES-1:0]        dec_exp;
  logic [FBITS-1:0]     dec_frac;

  // NOTE: every variable gets a default before any conditional update so the
  // block stays purely combinational with no inferred latch.
  always_comb begin
    run  = '0;
    done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!done && (s1_abs[i] == s1_abs[NBITS-2])) run = run + KW'(1);
      else                                          done = 1'b1;
    end
    dec_k    = s1_abs[NBITS-2] ? $signed(run - KW'(1)) : -$signed(run);
    // The first two bits (regime lead + terminator or second regime bit) are
    // always consumed, so the tail starts two bits down and shifts run-1 more.
    tail_sh  = s1_abs[NBITS-4:0] << (run - KW'(1));
    dec_exp  = tail_sh[ES+FBITS-1 -: ES];
    dec_frac = tail_sh[FBITS-1:0];
  end

  logic                 s2_valid, s2_sign, s2_zero, s2_inf;
  logic signed [KW-1:0] s2_k;
  logic [ES-1:0]        s2_exp;
  logic [FBITS-1:0]     s2_frac;
  logic                 s1_special;

  assign s1_special = s1_zero || s1_inf;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_k     <= '0;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_zero  <= s1_zero;
      s2_inf   <= s1_inf;
      s2_sign  <= s1_sign && !s1_special;
      s2_k     <= s1_special ? '0 : dec_k;
      s2_exp   <= s1_special ? '0 : dec_exp;
      s2_frac  <= s1_special ? '0 : dec_frac;
    end
  end

  // ---------------- S3: output register ----------------
  // NOTE: data registers are reset too, because the outputs must read as zero
  // after reset, not just be flagged invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      io.out_valid    <= 1'b0;
      io.out_sign     <= 1'b0;
      io.out_scale    <= '0;
      io.out_exponent <= '0;
      io.out_fraction <= '0;
      io.out_inf      <= 1'b0;
      io.out_zero     <= 1'b0;
    end else if (advance) begin
      io.out_valid    <= s2_valid;
      io.out_sign     <= s2_sign;
      io.out_scale    <= $signed({s2_k, s2_exp});
      io.out_exponent <= s2_exp;
      io.out_fraction <= s2_frac;
      io.out_inf      <= s2_inf;
      io.out_zero     <= s2_zero;
    end
  end

`ifdef POSIT_EXTRACT_CNT_EN
  // ---------------- Optional special-value counters ----------------
  logic out_xfer;
  assign out_xfer = io.out_valid && io.out_ready;

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_nar  <= '0;
      cnt_zero <= '0;
    end else begin
      if (out_xfer && io.out_inf && (cnt_nar != 16'hFFFF))
        cnt_nar <= cnt_nar + 16'd1;
      if (out_xfer && io.out_zero && (cnt_zero != 16'hFFFF))
        cnt_zero <= cnt_zero + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Directed bench for posit_extract_pipe (32-bit posit, ES=2); counter checks
// are compiled in when POSIT_EXTRACT_CNT_EN is defined.
module tb_posit_extract_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_extract_if #(.NBITS(32), .ES(2)) bus ();

`ifdef POSIT_EXTRACT_CNT_EN
  logic        clr_cnt;
  logic [15:0] cnt_nar, cnt_zero;
`endif

  posit_extract_pipe #(.NBITS(32), .ES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .io       (bus.slave)
`ifdef POSIT_EXTRACT_CNT_EN
    ,
    .clr_cnt  (clr_cnt),
    .cnt_nar  (cnt_nar),
    .cnt_zero (cnt_zero)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [39:0] res;   // {sign, scale[7:0], exp[1:0], frac[26:0], inf, zero}
  } vec_t;

  int tests = 0;
  int fails = 0;

  vec_t singles [8];
  vec_t stream  [8];

  function automatic logic [39:0] mk(logic s, int sc, int e, logic [26:0] f,
                                     logic inf, logic z);
    return {s, 8'(sc), 2'(e), f, inf, z};
  endfunction

  function automatic logic [39:0] pack_out();
    return {bus.out_sign, bus.out_scale, bus.out_exponent, bus.out_fraction,
            bus.out_inf, bus.out_zero};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    tests++;
    if (pack_out() !== 40'h0) begin
      fails++; $display("FAIL reset_fields got %h want 0", pack_out());
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  // One word at a time: check acceptance, latency and the decoded fields.
  task automatic test_single_words();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = singles[i].data;
      #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL single_in_ready[%0d] got %b want 1", i, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_data = '0;
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL single_early_valid[%0d] got %b want 0", i, bus.out_valid);
      end
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1) begin
        fails++; $display("FAIL single_valid[%0d] got %b want 1", i, bus.out_valid);
      end
      tests++;
      if (pack_out() !== singles[i].res) begin
        fails++;
        $display("FAIL single_fields[%0d] in %h got %h want %h", i,
                 singles[i].data, pack_out(), singles[i].res);
      end
    end
    @(negedge clk);
  endtask

  // Continuous stream with a 5-cycle downstream stall; a valid-bit model
  // predicts out_valid/in_ready and results must emerge once each, in order.
  task automatic test_stall_stream();
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    logic adv_m;
    logic [2:0] mv = 3'b000;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 5 && cyc < 10);
      bus.in_valid  = (sent < 8);
      bus.in_data   = (sent < 8) ? stream[sent].data : 32'h0;
      #1;
      adv_m = !mv[2] || bus.out_ready;
      tests++;
      if (bus.out_valid !== mv[2]) begin
        fails++; $display("FAIL stream_out_valid cyc %0d got %b want %b", cyc, bus.out_valid, mv[2]);
      end
      tests++;
      if (bus.in_ready !== adv_m) begin
        fails++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, adv_m);
      end
      if (mv[2]) begin
        tests++;
        if (pack_out() !== stream[got].res) begin
          fails++;
          $display("FAIL stream_fields cyc %0d item %0d got %h want %h", cyc, got,
                   pack_out(), stream[got].res);
        end
        if (bus.out_ready) got++;
      end
      if (bus.in_valid && adv_m) sent++;
      if (adv_m) mv = {mv[1:0], bus.in_valid};
      cyc++;
    end
    tests++;
    if (got != 8) begin
      fails++; $display("FAIL stream_count got %0d want 8 (cycle budget expired)", got);
    end
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL stream_extra_output got %b want 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = stream[i].data;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL midrst_prefill got %b want 1", bus.out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready);
    end
    tests++;
    if (pack_out() !== 40'h0) begin
      fails++; $display("FAIL midrst_fields got %h want 0", pack_out());
    end
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL midrst_stale got %b want 0", bus.out_valid);
      end
    end
  endtask

`ifdef POSIT_EXTRACT_CNT_EN
  task automatic push_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input logic [31:0] w4, input int n);
    logic [31:0] ws [5];
    ws = '{w0, w1, w2, w3, w4};
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = ws[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_counters();
    clr_cnt = 1'b0;
    push_words(32'h80000000, 32'h0, 32'h80000000, 32'h0, 32'h80000000, 5);
    tests++;
    if (cnt_nar !== 16'd3) begin
      fails++; $display("FAIL cnt_nar got %0d want 3", cnt_nar);
    end
    tests++;
    if (cnt_zero !== 16'd2) begin
      fails++; $display("FAIL cnt_zero got %0d want 2", cnt_zero);
    end
    // clr_cnt on the very cycle a NaR leaves the pipe.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'h80000000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    tests++;
    if (cnt_nar !== 16'd0) begin
      fails++; $display("FAIL cnt_clr_priority got %0d want 0", cnt_nar);
    end
    force dut.cnt_nar = 16'hFFFD;
    @(negedge clk);
    release dut.cnt_nar;
    push_words(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0, 4);
    tests++;
    if (cnt_nar !== 16'hFFFF) begin
      fails++; $display("FAIL cnt_saturate got %h want ffff", cnt_nar);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    singles[0] = '{32'h40000000, mk(0,    0, 0, 27'd0, 0, 0)};
    singles[1] = '{32'h48000000, mk(0,    1, 1, 27'd0, 0, 0)};
    singles[2] = '{32'hC0000000, mk(1,    0, 0, 27'd0, 0, 0)};
    singles[3] = '{32'h7FFFFFFF, mk(0,  120, 0, 27'd0, 0, 0)};
    singles[4] = '{32'h00000001, mk(0, -120, 0, 27'd0, 0, 0)};
    singles[5] = '{32'h00000000, mk(0,    0, 0, 27'd0, 0, 1)};
    singles[6] = '{32'h80000000, mk(0,    0, 0, 27'd0, 1, 0)};
    singles[7] = '{32'h40000001, mk(0,    0, 0, 27'd1, 0, 0)};

    stream[0] = '{32'h50000000, mk(0,    2, 2, 27'd0,         0, 0)};
    stream[1] = '{32'h38000000, mk(0,   -1, 3, 27'd0,         0, 0)};
    stream[2] = '{32'h4C000000, mk(0,    1, 1, 27'h4000000,   0, 0)};
    stream[3] = '{32'h60000000, mk(0,    4, 0, 27'd0,         0, 0)};
    stream[4] = '{32'hB8000000, mk(1,    1, 1, 27'd0,         0, 0)};
    stream[5] = '{32'h7FFFFFFE, mk(0,  116, 0, 27'd0,         0, 0)};
    stream[6] = '{32'hFFFFFFFF, mk(1, -120, 0, 27'd0,         0, 0)};
    stream[7] = '{32'h44000000, mk(0,    0, 0, 27'h4000000,   0, 0)};

`ifdef POSIT_EXTRACT_CNT_EN
    clr_cnt = 1'b0;
`endif
    test_reset();
    test_single_words();
    test_stall_stream();
    test_reset_midstream();
`ifdef POSIT_EXTRACT_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
